// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and controller state encodings.
package alu_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpShl = 3'b101,
    OpShr = 3'b110,
    OpMul = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } alu_state_t;

endpackage

// File: rtl/addsub_n.sv
// Parametrised ripple-carry add/subtract unit; sub=1 computes a + ~b + 1.
module addsub_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;

  always_comb begin
    bx   = b ^ {WIDTH{sub}};
    sum  = '0;
    c    = '0;
    c[0] = sub;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign carry    = c[WIDTH];
  // Signed overflow when carry into and out of the sign bit disagree.
  assign overflow = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add multiply
// that reuses the one add/subtract unit for partial-sum accumulation.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  alu_state_t         state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;   // {accumulator, remaining multiplier bits}
  logic [CW-1:0]      cnt_q;

  alu_op_t            op_t;
  logic [WIDTH-1:0]   add_x, add_y, add_sum;
  logic               add_sub, add_carry, add_ovf;
  logic [SHW-1:0]     shamt;
  logic               sh_big;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   res_d;
  logic               carry_d, ovf_d;

  assign op_t     = alu_op_t'(op);
  assign in_ready = (state_q == StIdle);
  assign shamt    = b[SHW-1:0];
  assign sh_big   = ({1'b0, shamt} >= (SHW+1)'(WIDTH));

  // While multiplying, the adder accumulates; otherwise it serves ADD/SUB.
  always_comb begin
    if (state_q == StBusy) begin
      add_x   = prod_q[2*WIDTH-1:WIDTH];
      add_y   = prod_q[0] ? mcand_q : '0;
      add_sub = 1'b0;
    end else begin
      add_x   = a;
      add_y   = b;
      add_sub = (op_t == OpSub);
    end
  end

  addsub_n #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a        (add_x),
    .b        (add_y),
    .sub      (add_sub),
    .sum      (add_sum),
    .carry    (add_carry),
    .overflow (add_ovf)
  );

  assign prod_next = {add_carry, add_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (op_t)
      OpAdd, OpSub: begin
        res_d   = add_sum;
        carry_d = add_carry;
        ovf_d   = add_ovf;
      end
      OpAnd: res_d = a & b;
      OpOr:  res_d = a | b;
      OpXor: res_d = a ^ b;
      OpShl: res_d = sh_big ? '0 : (a << shamt);
      OpShr: res_d = sh_big ? '0 : (a >> shamt);
      OpMul: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (op_t == OpMul) begin
              state_q <= StBusy;
              mcand_q <= a;
              prod_q  <= {{WIDTH{1'b0}}, b};
              cnt_q   <= '0;
            end else begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              result    <= res_d;
              carry     <= carry_d;
              zero      <= (res_d == '0);
              overflow  <= ovf_d;
            end
          end
        end
        StBusy: begin
          prod_q <= prod_next;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            result    <= prod_next[WIDTH-1:0];
            carry     <= 1'b0;
            zero      <= (prod_next[WIDTH-1:0] == '0);
            overflow  <= |prod_next[2*WIDTH-1:WIDTH];
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry, zero, overflow;

  int checks = 0;
  int errors = 0;

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    int             sh;
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    sh = int'(y[$clog2(W)-1:0]);
    case (o)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (sh >= W) ? '0 : (x << sh);
      3'd6: r = (sh >= W) ? '0 : (x >> sh);
      default: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        r = p[W-1:0];
        v = |p[2*W-1:W];
      end
    endcase
  endfunction

  // Model: 0 idle, 1 computing, 2 presenting result.
  int           m_phase = 0;
  int           m_wait = 0;
  bit           m_init = 1'b0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_r = '0, p_r = '0;
  logic         m_c = 1'b0, m_o = 1'b0, p_c = 1'b0, p_o = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init  = 1'b1;
      m_phase = 0;
      m_valid = 1'b0;
      m_r     = '0;
      m_c     = 1'b0;
      m_o     = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          ref_op(op, a, b, p_r, p_c, p_o);
          if (op == 3'd7) begin
            m_wait  = W;
            m_phase = 1;
          end else begin
            m_r = p_r; m_c = p_c; m_o = p_o; m_valid = 1'b1; m_phase = 2;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) begin
            m_r = p_r; m_c = p_c; m_o = p_o; m_valid = 1'b1; m_phase = 2;
          end
        end
        default: if (out_ready) begin
          m_valid = 1'b0;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model_in_ready", in_ready, (m_phase == 0));
      check("model_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("model_result", result, m_r);
        check("model_carry", carry, m_c);
        check("model_zero", zero, (m_r == '0));
        check("model_overflow", overflow, m_o);
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] er, input logic ec, input logic ez, input logic eo,
                        input int elat, input int hold);
    int lat;
    op = o; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    check("result", result, er);
    check("carry", carry, ec);
    check("zero", zero, ez);
    check("overflow", overflow, eo);
    if (hold > 0) begin
      op = 3'd0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_result", result, er);
        check("hold_zero", zero, ez);
        check("hold_in_ready", in_ready, 1'b0);
        check("hold_out_valid", out_valid, 1'b1);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_ready", in_ready, 1'b1);
    check("valid_dropped", out_valid, 1'b0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_flags", {carry, zero, overflow}, 3'b000);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);

    //     op    a      b      result c  z  o  lat hold
    run_op(3'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1, 0);
    run_op(3'd1, 8'h80, 8'h01, 8'h7F, 1, 0, 1, 1, 0);
    run_op(3'd7, 8'h10, 8'h11, 8'h10, 0, 0, 1, 9, 0);
    run_op(3'd7, 8'h0F, 8'h0F, 8'hE1, 0, 0, 0, 9, 0);
    run_op(3'd4, 8'hAA, 8'hAA, 8'h00, 0, 1, 0, 1, 5);
    run_op(3'd5, 8'h81, 8'h01, 8'h02, 0, 0, 0, 1, 0);
    run_op(3'd6, 8'h81, 8'h07, 8'h01, 0, 0, 0, 1, 0);
    run_op(3'd2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 1, 0);
    run_op(3'd3, 8'hF0, 8'h0F, 8'hFF, 0, 0, 0, 1, 0);
    run_op(3'd0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0);
    run_op(3'd1, 8'h05, 8'h07, 8'hFE, 0, 0, 0, 1, 0);
    run_op(3'd7, 8'h00, 8'hFF, 8'h00, 0, 1, 0, 9, 2);
    run_op(3'd7, 8'hFF, 8'hFF, 8'h01, 0, 0, 1, 9, 0);

    // Reset sampled on the third cycle after a MUL is accepted.
    op = 3'd7; a = 8'h10; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_result", result, 8'h00);
    check("abort_flags", {carry, zero, overflow}, 3'b000);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 1'b0);

    run_op(3'd0, 8'h12, 8'h34, 8'h46, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d want finish", checks);
    $fatal(1);
  end

endmodule
